// File: rtl/cdc_strobe_launcher_if.sv
// Input word stream of the CDC strobe launcher: one word per valid/ready transfer,
// with the per-word 4-phase ack mode select travelling alongside the data.
interface cdc_strobe_launcher_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              use_ack;

    modport master (
        output in_data,
        output in_valid,
        output use_ack,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  use_ack,
        output in_ready
    );
endinterface

// File: rtl/cdc_strobe_launcher.sv
// Source-side launcher for a strobe-qualified multi-bit CDC: drives a word, raises the
// strobe after a setup window, holds the word after the strobe, optionally waits for a 4-phase ack.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for a word; tx_data keeps the last launched word
// S_SETUP  | tx_data driven, strobe still low (setup window)
// S_STROBE | strobe high for its minimum width
// S_ACK_HI | 4-phase: strobe high, waiting for synchronized ack to rise
// S_ACK_LO | 4-phase: strobe low, waiting for synchronized ack to fall
// S_HOLD   | strobe low, tx_data held before the next word may be accepted
module cdc_strobe_launcher #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int STB_CYC   = 3,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cdc_strobe_launcher_if.slave in_if,
    input  logic                 ack_async,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_stb,
    output logic                 busy,
    output logic                 ack_err,
    output logic [7:0]           words_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_ACK_HI,
        S_ACK_LO,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(STB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DATA_W-1:0] tx_data_nx;
    logic              tx_stb_nx;
    logic              mode, mode_nx;
    logic              aborted, aborted_nx;
    logic              ack_err_nx;
    logic [7:0]        words_nx;
    logic              rdy_en;
    logic              ack_s1, ack_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            ack_s1 <= ack_async;
            ack_s  <= ack_s1;
            rdy_en <= 1'b1;
        end
    end

    assign in_if.in_ready = rdy_en && (state == S_IDLE);
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tx_data    <= '0;
            tx_stb     <= 1'b0;
            mode       <= 1'b0;
            aborted    <= 1'b0;
            ack_err    <= 1'b0;
            words_sent <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tx_data    <= tx_data_nx;
            tx_stb     <= tx_stb_nx;
            mode       <= mode_nx;
            aborted    <= aborted_nx;
            ack_err    <= ack_err_nx;
            words_sent <= words_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tx_data_nx = tx_data;
        tx_stb_nx  = tx_stb;
        mode_nx    = mode;
        aborted_nx = aborted;
        ack_err_nx = ack_err;
        words_nx   = words_sent;

        unique case (state)
            S_IDLE: begin
                if (in_if.in_valid && in_if.in_ready) begin
                    tx_data_nx = in_if.in_data;
                    mode_nx    = in_if.use_ack;
                    aborted_nx = 1'b0;
                    cnt_nx     = SETUP_LD;
                    state_nx   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    tx_stb_nx = 1'b1;
                    cnt_nx    = STB_LD;
                    state_nx  = S_STROBE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    if (mode) begin
                        cnt_nx   = TO_LD;
                        state_nx = S_ACK_HI;
                    end else begin
                        tx_stb_nx = 1'b0;
                        cnt_nx    = HOLD_LD;
                        state_nx  = S_HOLD;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            // An ack that is already high on entry completes the phase on the first cycle.
            S_ACK_HI: begin
                if (ack_s) begin
                    tx_stb_nx = 1'b0;
                    cnt_nx    = TO_LD;
                    state_nx  = S_ACK_LO;
                end else if (cnt == '0) begin
                    ack_err_nx = 1'b1;
                    aborted_nx = 1'b1;
                    tx_stb_nx  = 1'b0;
                    cnt_nx     = HOLD_LD;
                    state_nx   = S_HOLD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            // Strobe already fell on entry here, so an abort leaves through a single HOLD cycle.
            S_ACK_LO: begin
                if (!ack_s) begin
                    cnt_nx   = HOLD_LD;
                    state_nx = S_HOLD;
                end else if (cnt == '0) begin
                    ack_err_nx = 1'b1;
                    aborted_nx = 1'b1;
                    state_nx   = S_HOLD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                    if (!aborted) begin
                        words_nx = words_sent + 8'd1;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_strobe_launcher.sv
// Bench for cdc_strobe_launcher: directed steps plus randomized words, checked every cycle
// against a timeline model that derives strobe/busy/ready windows from edge arithmetic.
module tb_cdc_strobe_launcher;
    localparam int     S    = 2;
    localparam int     T    = 3;
    localparam int     H    = 2;
    localparam int     TO   = 64;
    localparam longint NONE = -1000;
    localparam longint NEVER = 1000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ack_async;
    logic [7:0] tx_data;
    logic       tx_stb;
    logic       busy;
    logic       ack_err;
    logic [7:0] words_sent;

    int n_cmp = 0;
    int n_bad = 0;

    cdc_strobe_launcher_if #(.DATA_W(8)) bus ();

    cdc_strobe_launcher #(
        .DATA_W(8), .SETUP_CYC(S), .STB_CYC(T), .HOLD_CYC(H), .TIMEOUT(TO), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bus), .ack_async(ack_async),
        .tx_data(tx_data), .tx_stb(tx_stb), .busy(busy), .ack_err(ack_err),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // model: edge numbers of the current word's milestones (value "after edge k")
    longint     e = 0;
    longint     acc = NONE, fall = NONE, idle = NONE, err_edge = NONE;
    longint     rdy_edge = NEVER;
    longint     m_ar = 0, m_af = 0, o_ar = 0, o_af = 0;
    logic [7:0] m_data = 8'd0, m_words = 8'd0;
    logic       m_err = 1'b0, m_abort = 1'b0, m_mode = 1'b0;
    logic       exp_ready = 1'b0, accepted = 1'b0;

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic model_clear();
        acc = NONE; fall = NONE; idle = NONE; err_edge = NONE;
        m_data = 8'd0; m_words = 8'd0; m_err = 1'b0; m_abort = 1'b0; m_mode = 1'b0;
        exp_ready = 1'b0;
    endtask

    // Ack is high at edges [a+ar, a+af); its synchronized copy is seen 2 edges later.
    task automatic plan(input longint a, input logic mode, input longint ar, input longint af);
        longint h0, r, f;
        acc = a;
        m_abort = 1'b0;
        err_edge = NONE;
        if (!mode) begin
            fall = a + S + T;
            idle = a + S + T + H;
        end else begin
            h0 = a + S + T + 1;
            r  = lmax(h0, a + ar + 2);
            if (r <= h0 + TO - 1 && r < a + af + 2) begin
                fall = r;
                f = lmax(r + 1, a + af + 2);
                if (f <= r + TO) begin
                    idle = f + H;
                end else begin
                    err_edge = r + TO;
                    idle = r + TO + 1;
                    m_abort = 1'b1;
                end
            end else begin
                fall = h0 + TO - 1;
                err_edge = fall;
                idle = fall + H;
                m_abort = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("tx_stb", 32'(e >= acc + S && e < fall), 32'(tx_stb));
        chk("busy", 32'(busy), 32'(e >= acc && e < idle));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("ack_err", 32'(ack_err), 32'(m_err));
        chk("words_sent", 32'(words_sent), 32'(m_words));
    endtask

    task automatic cycle();
        if (m_mode)
            ack_async = ((e + 1) >= acc + m_ar) && ((e + 1) < acc + m_af);
        else
            ack_async = 1'($urandom_range(0, 1));
        accepted = 1'b0;
        @(posedge clk);
        e++;
        if (!rst_n) begin
            model_clear();
            rdy_edge = e + 1;
        end else begin
            if (e == idle && !m_abort) m_words++;
            if (e == err_edge) m_err = 1'b1;
            if (bus.in_valid && exp_ready) begin
                accepted = 1'b1;
                m_data = bus.in_data;
                m_mode = bus.use_ack;
                m_ar = o_ar;
                m_af = o_af;
                plan(e, bus.use_ack, o_ar, o_af);
            end
            exp_ready = (e >= idle) && (e >= rdy_edge);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic offer(input logic [7:0] d, input logic ua, input longint ar, input longint af);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.use_ack = ua;
        o_ar = ar; o_af = af;
        accepted = 1'b0;
        while (!accepted && n < 400) begin
            cycle();
            n++;
        end
        chk("accept", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        bus.use_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_data = 8'($urandom);
            bus.use_ack = 1'($urandom_range(0, 1));
            cycle();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (!exp_ready && n < 500) begin
            cycle();
            n++;
        end
        chk("drain", 32'(exp_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tx_stb", 32'(tx_stb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        model_clear();
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("ready_first_clk", 32'(bus.in_ready), 32'd0);
        cycle();
        chk("ready_second_clk", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ar, af;
        rst_n = 1'b1;
        ack_async = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.use_ack = 1'b0;
        #2;
        do_reset();

        // T1: reset in the middle of the strobe
        offer(8'h5A, 1'b0, 0, 0);
        cycle(); cycle(); cycle();
        chk("t1_stb_before_reset", 32'(tx_stb), 32'd1);
        do_reset();

        // T2: single word without ack
        offer(8'h55, 1'b0, 0, 0);
        drain();
        chk("t2_words", 32'(words_sent), 32'd1);

        // T3: back-to-back with in_valid held high
        offer(8'hFF, 1'b0, 0, 0);
        offer(8'h00, 1'b0, 0, 0);
        offer(8'hA5, 1'b0, 0, 0);
        drain();
        chk("t3_words", 32'(words_sent), 32'd4);

        // T4: 4-phase ack rising 5 cycles after the strobe
        offer(8'hC3, 1'b1, S + 5, S + 11);
        drain();
        chk("t4_words", 32'(words_sent), 32'd5);
        chk("t4_ack_err", 32'(ack_err), 32'd0);

        // T5: ack never arrives
        offer(8'h3C, 1'b1, NEVER, NEVER + 1);
        drain();
        chk("t5_ack_err", 32'(ack_err), 32'd1);
        chk("t5_words", 32'(words_sent), 32'd5);

        // random mix of ack schedules, including early, late and never-falling acks
        for (int i = 0; i < 12; i++) begin
            ar = longint'($urandom_range(1, 80));
            af = ($urandom_range(0, 3) == 0) ? NEVER : ar + longint'($urandom_range(1, 90));
            offer(8'($urandom), 1'($urandom_range(0, 3) != 0), ar, af);
            gap(int'($urandom_range(0, 4)));
        end
        drain();
        chk("sticky_ack_err", 32'(ack_err), 32'd1);

        // T6: wrap of words_sent with random gaps
        do_reset();
        for (int i = 0; i < 256; i++) begin
            offer(8'($urandom), 1'b0, 0, 0);
            if ($urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 3)));
        end
        drain();
        chk("t6_wrap", 32'(words_sent), 32'd0);
        chk("t6_ack_err", 32'(ack_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
